// File: rtl/axis_packet_fifo_ram.sv
// Simple dual-port inferred RAM for axis_packet_fifo.
// One write port, one read port with a registered 1-cycle read.
module axis_packet_fifo_ram #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port: store one word per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered output, no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with tlast, stream or store-and-forward packet mode.
// Packet mode only releases whole packets and drops those that overflow.
module axis_packet_fifo #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 10,
    parameter string PACKET_MODE  = "TRUE",
    parameter string ALWAYS_VALID = "FALSE"
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic [15:0]           write_count,
    output logic [15:0]           read_count,
    output logic [15:0]           packet_count,
    output logic [15:0]           drop_count,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int RAM_WIDTH = DATA_WIDTH + 1;
    localparam bit IS_PKT    = (PACKET_MODE == "TRUE");
    localparam bit IS_AV     = (ALWAYS_VALID == "TRUE");

    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_DEPTH = PTR_WIDTH'(DEPTH);

    // Pointers and write-side state
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_commit_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic                 r_drop_pending;
    logic                 r_s_ready;
    logic [15:0]          r_pkt_cnt;
    logic [15:0]          r_drop_cnt;
    logic [15:0]          r_wcount;
    logic [15:0]          r_rcount;

    // Read-side state: one RAM read in flight plus a 2-entry skid stage
    logic                 r_rd_inflight;
    logic                 r_head_v;
    logic [RAM_WIDTH-1:0] r_head_d;
    logic                 r_tail_v;
    logic [RAM_WIDTH-1:0] r_tail_d;

    logic [PTR_WIDTH-1:0] w_wr_used;
    logic [PTR_WIDTH-1:0] w_cm_used;
    logic [PTR_WIDTH-1:0] w_wr_ptr_inc;
    logic                 w_full;
    logic                 w_in_fire;
    logic                 w_discard;
    logic                 w_ram_we;
    logic                 w_pkt_commit;
    logic                 w_pkt_drop;
    logic                 w_pop;
    logic                 w_pkt_dec;
    logic [1:0]           w_occ;
    logic [1:0]           w_occ_after_pop;
    logic                 w_rd_en;
    logic [RAM_WIDTH-1:0] w_ram_q;
    logic                 w_head_v_nxt;
    logic [RAM_WIDTH-1:0] w_head_d_nxt;
    logic                 w_tail_v_nxt;
    logic [RAM_WIDTH-1:0] w_tail_d_nxt;

    assign w_wr_used    = r_wr_ptr - r_rd_ptr;
    assign w_cm_used    = r_commit_ptr - r_rd_ptr;
    assign w_wr_ptr_inc = r_wr_ptr + PTR_ONE;
    assign w_full       = (w_wr_used == PTR_DEPTH);

    assign s_axis_tready = r_s_ready & (IS_PKT | ~w_full);

    assign w_in_fire    = s_axis_tvalid & s_axis_tready;
    assign w_discard    = IS_PKT & (w_full | r_drop_pending);
    assign w_ram_we     = w_in_fire & ~w_discard;
    assign w_pkt_commit = IS_PKT & w_ram_we & s_axis_tlast;
    assign w_pkt_drop   = w_in_fire & w_discard & s_axis_tlast;

    // The in-flight read is counted as occupancy so the stage never overfills
    assign w_occ = 2'(r_head_v) + 2'(r_tail_v) + 2'(r_rd_inflight);
    assign w_pop = r_head_v & m_axis_tready;
    assign w_occ_after_pop = w_occ - 2'(w_pop);
    assign w_rd_en = (r_rd_ptr != r_commit_ptr) && (w_occ_after_pop < 2'd2);
    assign w_pkt_dec = IS_PKT & w_pop & r_head_d[DATA_WIDTH];

    axis_packet_fifo_ram #(
        .WIDTH      (RAM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (aclk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata ({s_axis_tlast, s_axis_tdata}),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

    // Write side: advance, commit, or rewind the write pointer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s_ready      <= 1'b0;
            r_wr_ptr       <= '0;
            r_commit_ptr   <= '0;
            r_drop_pending <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            r_s_ready <= 1'b1;
            if (w_ram_we) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pkt_drop) begin
                r_wr_ptr <= r_commit_ptr;
            end
            if (!IS_PKT && w_ram_we) begin
                r_commit_ptr <= w_wr_ptr_inc;
            end
            if (w_pkt_commit) begin
                r_commit_ptr <= w_wr_ptr_inc;
            end
            if (w_in_fire && w_discard) begin
                r_drop_pending <= ~s_axis_tlast;
            end
            if (w_pkt_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Prefetch: issue RAM reads while committed data exists and the stage has room
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_ptr      <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Skid stage next state: shift on pop, then append the returning RAM word
    always_comb begin
        w_head_v_nxt = r_head_v;
        w_head_d_nxt = r_head_d;
        w_tail_v_nxt = r_tail_v;
        w_tail_d_nxt = r_tail_d;
        if (w_pop) begin
            w_head_v_nxt = r_tail_v;
            w_head_d_nxt = r_tail_d;
            w_tail_v_nxt = 1'b0;
            w_tail_d_nxt = '0;
        end
        if (r_rd_inflight) begin
            if (!w_head_v_nxt) begin
                w_head_v_nxt = 1'b1;
                w_head_d_nxt = w_ram_q;
            end else begin
                w_tail_v_nxt = 1'b1;
                w_tail_d_nxt = w_ram_q;
            end
        end
        if (!w_head_v_nxt) begin
            w_head_d_nxt = '0;
        end
    end

    // Skid stage registers drive the master outputs directly
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_head_v <= 1'b0;
            r_head_d <= '0;
            r_tail_v <= 1'b0;
            r_tail_d <= '0;
        end else begin
            r_head_v <= w_head_v_nxt;
            r_head_d <= w_head_d_nxt;
            r_tail_v <= w_tail_v_nxt;
            r_tail_d <= w_tail_d_nxt;
        end
    end

    // Complete-packet count; simultaneous commit and release cancel out
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt <= '0;
        end else if (w_pkt_commit && !w_pkt_dec) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end else if (!w_pkt_commit && w_pkt_dec) begin
            r_pkt_cnt <= r_pkt_cnt - 16'd1;
        end
    end

    // Registered level counts, one cycle behind the pointers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wcount <= '0;
            r_rcount <= '0;
        end else begin
            r_wcount <= 16'(w_wr_used) + 16'(w_occ);
            r_rcount <= 16'(w_cm_used) + 16'(w_occ);
        end
    end

    assign write_count   = r_wcount;
    assign read_count    = r_rcount;
    assign packet_count  = r_pkt_cnt;
    assign drop_count    = r_drop_cnt;
    assign m_axis_tvalid = IS_AV | r_head_v;
    assign m_axis_tdata  = r_head_d[DATA_WIDTH-1:0];
    assign m_axis_tlast  = r_head_d[DATA_WIDTH];

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Randomized bench for axis_packet_fifo: one stream-mode and one
// packet-mode instance, both 16 deep, checked against queue models.
module tb_axis_packet_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [15:0]   s_wc, s_rc, s_pc, s_dc;
    logic [DW-1:0] s_in_d = '0;
    logic          s_in_l = 1'b0;
    logic          s_in_v = 1'b0;
    logic          s_in_r;
    logic [DW-1:0] s_out_d;
    logic          s_out_l, s_out_v;
    logic          s_out_r = 1'b0;

    logic [15:0]   p_wc, p_rc, p_pc, p_dc;
    logic [DW-1:0] p_in_d = '0;
    logic          p_in_l = 1'b0;
    logic          p_in_v = 1'b0;
    logic          p_in_r;
    logic [DW-1:0] p_out_d;
    logic          p_out_l, p_out_v;
    logic          p_out_r = 1'b0;

    axis_packet_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PACKET_MODE  ("FALSE"),
        .ALWAYS_VALID ("FALSE")
    ) u_stream (
        .aclk          (clk),
        .aresetn       (rst_n),
        .write_count   (s_wc),
        .read_count    (s_rc),
        .packet_count  (s_pc),
        .drop_count    (s_dc),
        .s_axis_tdata  (s_in_d),
        .s_axis_tlast  (s_in_l),
        .s_axis_tvalid (s_in_v),
        .s_axis_tready (s_in_r),
        .m_axis_tdata  (s_out_d),
        .m_axis_tlast  (s_out_l),
        .m_axis_tvalid (s_out_v),
        .m_axis_tready (s_out_r)
    );

    axis_packet_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PACKET_MODE  ("TRUE"),
        .ALWAYS_VALID ("FALSE")
    ) u_packet (
        .aclk          (clk),
        .aresetn       (rst_n),
        .write_count   (p_wc),
        .read_count    (p_rc),
        .packet_count  (p_pc),
        .drop_count    (p_dc),
        .s_axis_tdata  (p_in_d),
        .s_axis_tlast  (p_in_l),
        .s_axis_tvalid (p_in_v),
        .s_axis_tready (p_in_r),
        .m_axis_tdata  (p_out_d),
        .m_axis_tlast  (p_out_l),
        .m_axis_tvalid (p_out_v),
        .m_axis_tready (p_out_r)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [DW:0] s_q[$];
    logic [DW:0] p_q[$];
    int cyc     = 0;
    int s_acc   = 0;
    int s_first = -1;
    int p_first = -1;
    int p_drops = 0;
    int p_npkt  = 0;
    int t_last  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output scoreboards and stream-side acceptance tracking
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            int held;
            logic [DW:0] e;
            held = s_q.size();
            if (s_out_v && s_first < 0) s_first = cyc;
            if (p_out_v && p_first < 0) p_first = cyc;
            if (s_out_v && s_out_r) begin
                if (s_q.size() == 0) chk("s_extra", {s_out_l, s_out_d}, 0);
                else begin
                    e = s_q.pop_front();
                    chk("s_word", {s_out_l, s_out_d}, e);
                end
            end
            if (s_in_v && held < DEPTH) chk("s_rdy", s_in_r, 1);
            if (s_in_v && s_in_r) begin
                s_q.push_back({s_in_l, s_in_d});
                s_acc++;
            end
            if (p_out_v && p_out_r) begin
                if (p_q.size() == 0) chk("p_extra", {p_out_l, p_out_d}, 0);
                else begin
                    e = p_q.pop_front();
                    if (p_out_l) p_npkt--;
                    chk("p_word", {p_out_l, p_out_d}, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain_s(input int lim);
        int c = 0;
        s_out_r = 1'b1;
        while (s_q.size() != 0 && c < lim) begin
            tick();
            c++;
        end
        chk("s_drain", s_q.size(), 0);
    endtask

    task automatic drain_p(input int lim, input bit rnd);
        int c = 0;
        while (p_q.size() != 0 && c < lim) begin
            p_out_r = rnd ? ($urandom_range(3) != 0) : 1'b1;
            tick();
            c++;
        end
        p_out_r = 1'b1;
        chk("p_drain", p_q.size(), 0);
        settle(4);
        chk("p_wc_empty", p_wc, 0);
        chk("p_rc_empty", p_rc, 0);
        chk("p_pc_empty", p_pc, 0);
    endtask

    // Model: with the reader stalled and settled, the output stage holds
    // min(2, held) committed words; the rest occupy RAM. A packet survives
    // only if it fits in the remaining RAM space.
    task automatic send_pkt(input int len, input int base, input bit gaps);
        int held, ram_used;
        held = p_q.size();
        ram_used = held - ((held < 2) ? held : 2);
        if (len <= DEPTH - ram_used) begin
            for (int i = 0; i < len; i++)
                p_q.push_back({(i == len - 1), DW'(base + i)});
            p_npkt++;
        end else begin
            p_drops++;
        end
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                p_in_v = 1'b0;
                tick();
            end
            p_in_v = 1'b1;
            p_in_d = DW'(base + i);
            p_in_l = (i == len - 1);
            if (i == len - 1) t_last = cyc + 1;
            tick();
        end
        p_in_v = 1'b0;
        p_in_l = 1'b0;
        settle(3);
    endtask

    task automatic chk_p_levels(input string tag);
        chk({tag, "_dc"}, p_dc, p_drops & 16'hffff);
        chk({tag, "_pc"}, p_pc, p_npkt);
        chk({tag, "_wc"}, p_wc, p_q.size());
        chk({tag, "_rc"}, p_rc, p_q.size());
    endtask

    initial begin
        int a0, t0, idx;
        settle(3);
        rst_n = 1'b1;
        tick();
        chk("rst_s_valid", s_out_v, 0);
        chk("rst_p_valid", p_out_v, 0);
        chk("rst_s_ready", s_in_r, 1);
        chk("rst_p_wc", p_wc, 0);
        chk("rst_p_dc", p_dc, 0);

        // Stream: back-to-back 1..16, reader always ready
        s_out_r = 1'b1;
        t0 = 0;
        for (int i = 1; i <= 16; i++) begin
            s_in_v = 1'b1;
            s_in_d = DW'(i);
            s_in_l = (i == 16);
            if (i == 1) t0 = cyc + 1;
            tick();
        end
        s_in_v = 1'b0;
        s_in_l = 1'b0;
        settle(5);
        chk("s_latency", s_first - t0, 2);
        chk("s_seq_out", s_q.size(), 0);
        chk("s_pc_zero", s_pc, 0);

        // Stream: stalled reader, offer 20 words
        s_out_r = 1'b0;
        a0 = s_acc;
        for (int c = 0; c < 40 && (s_acc - a0) < 20; c++) begin
            s_in_v = 1'b1;
            s_in_d = DW'(32'h100 + (s_acc - a0));
            tick();
        end
        s_in_v = 1'b0;
        settle(2);
        chk("s_full_acc", s_acc - a0, 18);
        chk("s_full_wc", s_wc, 18);
        chk("s_full_rc", s_rc, 18);
        chk("s_full_rdy", s_in_r, 0);
        s_out_r = 1'b1;
        for (int c = 0; c < 40 && (s_acc - a0) < 20; c++) begin
            idx = s_acc - a0;
            s_in_v = 1'b1;
            s_in_d = DW'(32'h100 + idx);
            s_in_l = (idx == 19);
            tick();
        end
        s_in_v = 1'b0;
        s_in_l = 1'b0;
        chk("s_rest_acc", s_acc - a0, 20);
        drain_s(100);
        settle(3);
        chk("s_wc_empty", s_wc, 0);

        // Stream: random traffic on both sides
        for (int c = 0; c < 600; c++) begin
            s_in_v  = ($urandom_range(3) != 0);
            s_in_d  = $urandom;
            s_in_l  = ($urandom_range(7) == 0);
            s_out_r = (c < 300) ? ($urandom_range(1) != 0) : ($urandom_range(4) != 0);
            tick();
        end
        s_in_v = 1'b0;
        drain_s(200);
        settle(3);
        chk("s_rnd_wc", s_wc, 0);
        chk("s_rnd_rc", s_rc, 0);

        // Packet: 5-word packet held until its tlast is stored
        p_out_r = 1'b0;
        send_pkt(5, 32'hA0, 1'b0);
        tick();
        chk("p_latency", p_first - t_last, 2);
        chk("p_head", p_out_d, 32'hA0);
        chk_p_levels("p5");
        drain_p(50, 1'b0);

        // Packet: second 10-word packet overflows behind the first
        p_out_r = 1'b0;
        send_pkt(10, 32'hB00, 1'b0);
        send_pkt(10, 32'hC00, 1'b0);
        chk_p_levels("p10");
        drain_p(100, 1'b0);

        // Packet: over-length packet dropped, next small one intact
        p_out_r = 1'b0;
        send_pkt(40, 32'hD00, 1'b0);
        chk_p_levels("p40");
        send_pkt(3, 32'hE00, 1'b0);
        chk_p_levels("p3");
        drain_p(50, 1'b0);

        // Packet: random rounds of bursts then random drains
        for (int r = 0; r < 8; r++) begin
            int np;
            p_out_r = 1'b0;
            np = $urandom_range(4, 1);
            for (int k = 0; k < np; k++)
                send_pkt($urandom_range(20, 1), $urandom, 1'b1);
            chk_p_levels("prnd");
            drain_p(2000, 1'b1);
        end

        // Reset mid-packet while the output is valid
        p_out_r = 1'b0;
        send_pkt(4, 32'hF00, 1'b0);
        chk("pre_rst_valid", p_out_v, 1);
        p_in_v = 1'b1;
        p_in_d = 32'hF10;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", p_out_v, 0);
        chk("rst_async_rdy", p_in_r, 0);
        p_in_v = 1'b0;
        p_q.delete();
        s_q.delete();
        p_drops = 0;
        p_npkt = 0;
        tick();
        chk("rst_wc", p_wc, 0);
        chk("rst_rc", p_rc, 0);
        chk("rst_pc", p_pc, 0);
        chk("rst_dc", p_dc, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_low", p_in_r, 0);
        tick();
        chk("rel_rdy_high", p_in_r, 1);
        p_out_r = 1'b0;
        send_pkt(3, 32'h700, 1'b0);
        chk_p_levels("post_rst");
        drain_p(50, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
